ra1shd_mfault: RTL and testbench
================================

RA1SHD_MFAULT -- requirements
Module: ra1shd_mfault

Interface
REQ-001 Parameter BITS, default 32: data word width.
REQ-002 Parameter AW, default 12: address width.
REQ-003 Parameter NF, default 4: number of fault entries, 1..16.
REQ-004 Parameter FADDR, default all-ones, packed NF*AW: faulty address per entry; entry i occupies bits [i*AW +: AW].
REQ-005 Parameter FBIT, default 0, packed NF*8: faulty bit index per entry; values >= BITS disable that entry.
REQ-006 Parameter FTYPE, default 0, packed NF*2: fault type per entry: 0 SA0, 1 SA1, 2 TF-up (cell cannot rise 0->1), 3 TF-down (cell cannot fall 1->0).
REQ-007 CLK  in  1: single clock; all state on posedge.
REQ-008 RSTN  in  1: asynchronous, active-low reset.
REQ-009 CEN  in  1: chip enable, active-low, passed to macro.
REQ-010 WEN  in  1: write enable, active-low (0 write, 1 read), passed to macro.
REQ-011 A  in  AW: address, passed to macro.
REQ-012 D  in  BITS: write data, passed to macro.
REQ-013 OEN  in  1: output enable, active-low, passed to macro.
REQ-014 Q  out  BITS: read data, macro output with fault overrides applied.
REQ-015 FEN  in  1: fault enable; 0 gives fault-free behaviour.
REQ-016 FHIT  out  1: high for the read cycle whose data matched at least one active entry.
REQ-017 FCNT  out  16: count of faulty reads, saturating.

Function
REQ-018 The block SHALL instantiate one RA1SHD macro with all memory ports connected unmodified; the macro output feeds the override logic.
REQ-019 At the posedge where CEN=0 and WEN=1, the block SHALL capture A into a read-address latch and set read-valid.
- A posedge with CEN=1 or WEN=0 SHALL clear read-valid and leave the address latch unchanged.
REQ-020 Entry i is active when FEN=1, FBIT[i] < BITS, read-valid=1 and latched address == FADDR[i].
REQ-021 Q bit override while entry i is active and OEN=0:
- SA0: bit forced to 0.
- SA1: bit forced to 1.
- TF-up/TF-down: bit forced to shadow[i].
REQ-022 Q SHALL equal the macro output bit-for-bit when no entry is active or OEN=1; the override SHALL be combinational with zero added latency.
REQ-023 Several entries on the same address with different bits SHALL all apply; on the same address and bit, the lowest index SHALL win.
REQ-024 Shadow[i] update (TF entries only) on a posedge write (CEN=0, WEN=0, A==FADDR[i]):
- FEN=1, TF-up: shadow holds when shadow=0 and D bit=1; otherwise takes the D bit.
- FEN=1, TF-down: mirror rule (holds when shadow=1 and D bit=0).
- FEN=0: shadow takes the D bit unconditionally.
REQ-025 At each read-capture posedge, FHIT SHALL register 1 iff any entry will be active for that read (OEN ignored); otherwise 0.
REQ-026 FCNT SHALL increment by 1 at each posedge that sets FHIT to 1, and saturate at 16'hFFFF.
REQ-027 Toggling FEN mid-sequence SHALL take effect on Q combinationally and on FHIT/FCNT/shadow at the next posedge.

Reset
REQ-028 RSTN=0 SHALL asynchronously set: address latch 0, read-valid 0, FHIT 0, FCNT 0, TF-up shadows 0, TF-down shadows 1.
- Q therefore equals the macro output during reset.
REQ-029 Macro contents SHALL NOT be affected by reset.
REQ-030 Reset release SHALL be synchronised internally; the first capture occurs at the second posedge after RSTN rises.

Structure
REQ-031 Package ra1shd_mfault_pkg SHALL hold the fault-type codes (FT_SA0, FT_SA1, FT_TFUP, FT_TFDN) and the FCNT width constant.
REQ-032 Per-entry match, shadow and override-mask logic SHALL be one sub-module, ra1shd_fault_entry, generated NF times.

Verification
REQ-033 Entry0 SA0 at 12'h7FB, bit 28, FEN=1: write 32'hFFFFFFFF to 12'h7FB, then read it -> Q=32'hEFFFFFFF, FHIT=1, FCNT=1.
REQ-034 Same setup, FEN=0 -> Q=32'hFFFFFFFF, FHIT=0, FCNT unchanged.
REQ-035 Entry1 TF-up at 12'h010, bit 0, after reset: write 1, then read -> Q[0]=0; write 0, write 1, then read -> Q[0]=0.
REQ-036 Entry2 SA1 at 12'h020, bit 3, plus entry3 SA0 at 12'h020, bit 3: write 0, then read -> Q[3]=1 (lowest index wins).
REQ-037 FCNT preloaded to 16'hFFFE via reads: two faulty reads -> FCNT=16'hFFFF and holds; assert RSTN=0 mid-read -> FHIT=0 and FCNT=0 immediately.

Source files
------------

// File: rtl/ra1shd_mfault_pkg.sv
// Shared constants for the RA1SHD fault-injection wrapper: fault-type codes and counter width.
package ra1shd_mfault_pkg;

  localparam logic [1:0] FT_SA0  = 2'd0;
  localparam logic [1:0] FT_SA1  = 2'd1;
  localparam logic [1:0] FT_TFUP = 2'd2;
  localparam logic [1:0] FT_TFDN = 2'd3;

  localparam int unsigned FCNT_W = 16;

endpackage

// File: rtl/ra1shd.sv
// Behavioural model of the RA1SHD single-port SRAM macro: registered read, write-through on write.
// Contents have no reset. This model drives zero rather than high-impedance while OEN=1.
module ra1shd #(
  parameter int unsigned BITS = 32,
  parameter int unsigned AW   = 12
) (
  input  logic            CLK,
  input  logic            CEN,
  input  logic            WEN,
  input  logic [AW-1:0]   A,
  input  logic [BITS-1:0] D,
  input  logic            OEN,
  output logic [BITS-1:0] Q
);

  logic [BITS-1:0] mem_q [2**AW];
  logic [BITS-1:0] dout_d, dout_q;

  always_comb begin
    dout_d = dout_q;
    if (!CEN) dout_d = WEN ? mem_q[A] : D;
  end

  always_ff @(posedge CLK) begin
    if (!CEN && !WEN) mem_q[A] <= D;
    dout_q <= dout_d;
  end

  always_comb begin
    Q = OEN ? '0 : dout_q;
  end

endmodule

// File: rtl/ra1shd_fault_entry.sv
// One fault entry: address match against the latched read address, one-hot bit mask,
// forced value and the transition-fault shadow cell.
module ra1shd_fault_entry
  import ra1shd_mfault_pkg::*;
#(
  parameter int unsigned   Bits  = 32,
  parameter int unsigned   Aw    = 12,
  parameter logic [Aw-1:0] FAddr = '1,
  parameter logic [7:0]    FBit  = 8'd0,
  parameter logic [1:0]    FType = FT_SA0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fen_i,
  input  logic            rd_valid_i,
  input  logic [Aw-1:0]   rd_addr_i,
  input  logic            cen_i,
  input  logic            wen_i,
  input  logic [Aw-1:0]   a_i,
  input  logic [Bits-1:0] d_i,
  output logic            active_o,
  output logic            will_hit_o,
  output logic [Bits-1:0] mask_o,
  output logic            force_o
);

  localparam bit Valid     = (32'(FBit) < Bits);
  localparam bit ShadowRst = (FType == FT_TFDN);

  logic shadow_d, shadow_q;
  logic dbit;

  always_comb begin
    mask_o = '0;
    for (int unsigned i = 0; i < Bits; i++) mask_o[i] = Valid && (32'(FBit) == i);
  end

  always_comb begin
    active_o   = fen_i && Valid && rd_valid_i && (rd_addr_i == FAddr);
    will_hit_o = fen_i && Valid && (a_i == FAddr);
    if (FType == FT_SA0)      force_o = 1'b0;
    else if (FType == FT_SA1) force_o = 1'b1;
    else                      force_o = shadow_q;
  end

  // The shadow tracks what the faulty cell really holds; a blocked transition keeps the old value.
  always_comb begin
    dbit     = |(d_i & mask_o);
    shadow_d = shadow_q;
    if (!cen_i && !wen_i && (a_i == FAddr)) begin
      shadow_d = dbit;
      if (fen_i && (FType == FT_TFUP) && !shadow_q && dbit) shadow_d = shadow_q;
      if (fen_i && (FType == FT_TFDN) && shadow_q && !dbit) shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shadow_q <= ShadowRst;
    else         shadow_q <= shadow_d;
  end

endmodule

// File: rtl/ra1shd_mfault.sv
// RA1SHD wrapper with parameterised stuck-at / transition fault injection on the read path,
// plus a fault-hit flag and saturating faulty-read counter.
module ra1shd_mfault
  import ra1shd_mfault_pkg::*;
#(
  parameter int unsigned       BITS  = 32,
  parameter int unsigned       AW    = 12,
  parameter int unsigned       NF    = 4,
  parameter logic [NF*AW-1:0]  FADDR = '1,
  parameter logic [NF*8-1:0]   FBIT  = '0,
  parameter logic [NF*2-1:0]   FTYPE = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [AW-1:0]     A,
  input  logic [BITS-1:0]   D,
  input  logic              OEN,
  output logic [BITS-1:0]   Q,
  input  logic              FEN,
  output logic              FHIT,
  output logic [FCNT_W-1:0] FCNT
);

  logic [BITS-1:0]   macro_q;
  logic              arm_q;
  logic              capture;
  logic              rd_valid_d, rd_valid_q;
  logic [AW-1:0]     rd_addr_d, rd_addr_q;
  logic              fhit_d, fhit_q;
  logic [FCNT_W-1:0] fcnt_d, fcnt_q;
  logic [NF-1:0]     active, will_hit, force_val;
  logic [BITS-1:0]   mask [NF];

  ra1shd #(
    .BITS (BITS),
    .AW   (AW)
  ) u_macro (
    .CLK (CLK),
    .CEN (CEN),
    .WEN (WEN),
    .A   (A),
    .D   (D),
    .OEN (OEN),
    .Q   (macro_q)
  );

  for (genvar i = 0; i < NF; i++) begin : g_entry
    ra1shd_fault_entry #(
      .Bits  (BITS),
      .Aw    (AW),
      .FAddr (FADDR[i*AW +: AW]),
      .FBit  (FBIT[i*8 +: 8]),
      .FType (FTYPE[i*2 +: 2])
    ) u_entry (
      .clk_i      (CLK),
      .rst_ni     (RSTN),
      .fen_i      (FEN),
      .rd_valid_i (rd_valid_q),
      .rd_addr_i  (rd_addr_q),
      .cen_i      (CEN),
      .wen_i      (WEN),
      .a_i        (A),
      .d_i        (D),
      .active_o   (active[i]),
      .will_hit_o (will_hit[i]),
      .mask_o     (mask[i]),
      .force_o    (force_val[i])
    );
  end

  // arm_q holds off read capture for one posedge after reset release.
  always_comb begin
    capture    = arm_q && !CEN && WEN;
    rd_valid_d = capture;
    rd_addr_d  = capture ? A : rd_addr_q;
    fhit_d     = capture && (|will_hit);
    fcnt_d     = fcnt_q;
    if (fhit_d && (fcnt_q != '1)) fcnt_d = fcnt_q + FCNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      arm_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      fhit_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      arm_q      <= 1'b1;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      fhit_q     <= fhit_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Apply highest index first so the lowest index wins on a shared bit.
  always_comb begin
    Q = macro_q;
    if (!OEN) begin
      for (int i = NF - 1; i >= 0; i--) begin
        if (active[i]) Q = force_val[i] ? (Q | mask[i]) : (Q & ~mask[i]);
      end
    end
  end

  assign FHIT = fhit_q;
  assign FCNT = fcnt_q;

endmodule

// File: tb/tb_ra1shd_mfault.sv
// Directed bench for ra1shd_mfault: SA0/SA1/TF-up faults, FEN/OEN gating, counter saturation
// and reset behaviour, checked with immediate assertions against hand-computed values.
module tb_ra1shd_mfault;

  logic        clk, rst_n, cen, wen, oen, fen, fhit;
  logic [11:0] a;
  logic [31:0] d, q;
  logic [15:0] fcnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  ra1shd_mfault #(
    .BITS  (32),
    .AW    (12),
    .NF    (4),
    .FADDR ({12'h020, 12'h020, 12'h010, 12'h7FB}),
    .FBIT  ({8'd3, 8'd3, 8'd0, 8'd28}),
    .FTYPE ({2'd0, 2'd1, 2'd2, 2'd0})
  ) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .CEN  (cen),
    .WEN  (wen),
    .A    (a),
    .D    (d),
    .OEN  (oen),
    .Q    (q),
    .FEN  (fen),
    .FHIT (fhit),
    .FCNT (fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    cen = 1'b0; wen = 1'b0; a = addr; d = data;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] addr);
    @(negedge clk);
    cen = 1'b0; wen = 1'b1; a = addr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    cen = 1'b1; wen = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; cen = 1'b1; wen = 1'b1; a = '0; d = '0; oen = 1'b0; fen = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fhit", 32'(fhit), 32'd0);
    check("rst_fcnt", 32'(fcnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // SA0 entry 0, bit 28
    wr(12'h7FB, 32'hFFFF_FFFF);
    rd(12'h7FB);
    exp_cnt = 1;
    check("sa0_q", q, 32'hEFFF_FFFF);
    check("sa0_fhit", 32'(fhit), 32'd1);
    check("sa0_fcnt", 32'(fcnt), 32'(exp_cnt));
    idle();
    check("idle_fhit", 32'(fhit), 32'd0);
    check("idle_q", q, 32'hFFFF_FFFF);

    // FEN=0 read, then FEN raised combinationally within the same read cycle
    fen = 1'b0;
    rd(12'h7FB);
    check("fen0_q", q, 32'hFFFF_FFFF);
    check("fen0_fhit", 32'(fhit), 32'd0);
    check("fen0_fcnt", 32'(fcnt), 32'(exp_cnt));
    fen = 1'b1;
    #1;
    check("fen_toggle_q", q, 32'hEFFF_FFFF);
    check("fen_toggle_fhit", 32'(fhit), 32'd0);

    // TF-up entry 1, bit 0
    wr(12'h010, 32'h1);
    rd(12'h010);
    exp_cnt++;
    check("tfup_q1", q, 32'h0);
    check("tfup_fhit", 32'(fhit), 32'd1);
    check("tfup_fcnt", 32'(fcnt), 32'(exp_cnt));
    wr(12'h010, 32'h0);
    wr(12'h010, 32'h1);
    rd(12'h010);
    exp_cnt++;
    check("tfup_q2", q, 32'h0);
    fen = 1'b0;
    wr(12'h010, 32'h1);
    fen = 1'b1;
    rd(12'h010);
    exp_cnt++;
    check("tfup_fen0_wr_q", q, 32'h1);
    check("tfup_fcnt2", 32'(fcnt), 32'(exp_cnt));

    // SA1 entry 2 and SA0 entry 3 on the same bit
    wr(12'h020, 32'h0);
    rd(12'h020);
    exp_cnt++;
    check("prio_q", q, 32'h8);
    check("prio_fhit", 32'(fhit), 32'd1);
    oen = 1'b1;
    #1;
    check("oen1_q", q, 32'h0);
    oen = 1'b0;

    // Back-to-back faulty reads up to saturation
    @(negedge clk);
    cen = 1'b0; wen = 1'b1; a = 12'h7FB;
    repeat (32'hFFFE - exp_cnt) @(posedge clk);
    #1;
    check("pre_sat_fcnt", 32'(fcnt), 32'hFFFE);
    @(posedge clk); #1;
    check("sat_fcnt", 32'(fcnt), 32'hFFFF);
    check("sat_fhit", 32'(fhit), 32'd1);
    @(posedge clk); #1;
    check("sat_hold_fcnt", 32'(fcnt), 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_fhit", 32'(fhit), 32'd0);
    check("async_rst_fcnt", 32'(fcnt), 32'd0);
    check("async_rst_q", q, 32'hFFFF_FFFF);

    // Read held across release: no capture until the second posedge
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel1_fhit", 32'(fhit), 32'd0);
    check("rel1_fcnt", 32'(fcnt), 32'd0);
    check("rel1_q", q, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("rel2_fhit", 32'(fhit), 32'd1);
    check("rel2_fcnt", 32'(fcnt), 32'd1);
    check("rel2_q", q, 32'hEFFF_FFFF);

    // TF-up shadow returns to 0 after reset while the macro still holds 1
    rd(12'h010);
    check("shadow_rst_q", q, 32'h0);
    check("shadow_rst_fcnt", 32'(fcnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
